// File: rtl/cache_bus_pkg.sv
// Shared snooping-bus definitions: arbiter state encoding, bus command codes
// and snoop result codes, plus the snoop-code normalisation helper.
package cache_bus_pkg;

  // Transaction phases of the bus arbiter.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_SNOOP   = 3'd2,
    ST_DATA    = 3'd3,
    ST_RELEASE = 3'd4
  } bus_state_e;

  // Bus command codes; anything not listed is handled as a data-carrying command.
  localparam int unsigned CMD_NOP        = 0;
  localparam int unsigned CMD_READ       = 1;
  localparam int unsigned CMD_WRITE      = 2;
  localparam int unsigned CMD_INVALIDATE = 3;
  localparam int unsigned CMD_RWIM       = 4;

  // Snoop result codes.
  typedef logic [1:0] snoop_t;
  localparam snoop_t SNOOP_HIT   = 2'b00;
  localparam snoop_t SNOOP_HITM  = 2'b01;
  localparam snoop_t SNOOP_NOHIT = 2'b10;

  // The reserved code 2'b11 is folded onto NOHIT.
  function automatic snoop_t snoop_normalize(input snoop_t s);
    return (s == 2'b11) ? SNOOP_NOHIT : s;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder.
// Ports:
//   req      in  N      request vector
//   ptr      in  PTR_W  index with highest priority; search ascends with wrap
//   winner_c out N      one-hot winner, all-zero when nothing is requested
//   any_c    out 1      at least one request is present
module rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner_c,
  output logic             any_c
);

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    winner_c = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PTR_W'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        winner_c[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  assign any_c = |req;

endmodule

// File: rtl/shared_bus_arbiter.sv
// Shared snooping-bus arbiter: grants the bus round-robin among REQUESTERS
// masters and walks each transaction through address broadcast, snoop-result
// collection, data transfer and release. Single driver of the command/address
// lines and single source of grants.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   req                 per-master request, held until that master sees done
//   cmd_in / addr_in    per-master command / address, slice i = master i
//   snoop_valid/in      snoop result strobe and code (sampled in SNOOP only)
//   data_done           last data beat (sampled in DATA only)
//   gnt                 one-hot grant or zero
//   bus_valid           one-cycle command/address broadcast strobe
//   bus_cmd / bus_addr  broadcast command / address, held until next grant
//   snoop_result        captured snoop result, held until next capture
//   done                one-cycle transaction-complete pulse
//   busy                high whenever the arbiter is not idle
module shared_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int unsigned REQUESTERS   = 4,
  parameter int unsigned COMMAND_SIZE = 8,
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned SNOOP_WAIT   = 3
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [REQUESTERS-1:0]              req,
  input  logic [REQUESTERS*COMMAND_SIZE-1:0] cmd_in,
  input  logic [REQUESTERS*ADDRESS_SIZE-1:0] addr_in,
  input  logic                               snoop_valid,
  input  logic [1:0]                         snoop_in,
  input  logic                               data_done,
  output logic [REQUESTERS-1:0]              gnt,
  output logic                               bus_valid,
  output logic [COMMAND_SIZE-1:0]            bus_cmd,
  output logic [ADDRESS_SIZE-1:0]            bus_addr,
  output logic [1:0]                         snoop_result,
  output logic                               done,
  output logic                               busy
);

  localparam int unsigned PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int unsigned CNT_W = $clog2(SNOOP_WAIT + 1);

  bus_state_e              state_q, state_d;
  logic [REQUESTERS-1:0]   gnt_q, gnt_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PTR_W-1:0]        win_q, win_d;
  logic [COMMAND_SIZE-1:0] cmd_q, cmd_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  snoop_t                  snoop_q, snoop_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    bus_valid_q, bus_valid_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  logic [REQUESTERS-1:0]   pick_onehot;
  logic                    pick_any;
  logic [PTR_W-1:0]        pick_idx;
  logic [COMMAND_SIZE-1:0] sel_cmd;
  logic [ADDRESS_SIZE-1:0] sel_addr;
  logic [PTR_W-1:0]        ptr_after;
  logic                    snoop_expired;
  logic                    is_invalidate;
  logic                    to_release;

  rr_picker #(
    .N     (REQUESTERS),
    .PTR_W (PTR_W)
  ) u_picker (
    .req      (req),
    .ptr      (ptr_q),
    .winner_c (pick_onehot),
    .any_c    (pick_any)
  );

  // Encode the one-hot winner and select its command/address slices.
  always_comb begin
    pick_idx = '0;
    sel_cmd  = '0;
    sel_addr = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      if (pick_onehot[i]) begin
        pick_idx = PTR_W'(i);
        sel_cmd  = cmd_in[i*COMMAND_SIZE +: COMMAND_SIZE];
        sel_addr = addr_in[i*ADDRESS_SIZE +: ADDRESS_SIZE];
      end
    end
  end

  // Priority moves to the master just after the one being served.
  assign ptr_after     = (win_q == PTR_W'(REQUESTERS - 1)) ? '0 : win_q + PTR_W'(1);
  // The counter holds the number of SNOOP cycles already spent without a result.
  assign snoop_expired = (cnt_q == CNT_W'(SNOOP_WAIT - 1));
  assign is_invalidate = (cmd_q == COMMAND_SIZE'(CMD_INVALIDATE));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    snoop_d     = snoop_q;
    cnt_d       = cnt_q;
    bus_valid_d = 1'b0;
    done_d      = 1'b0;
    to_release  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d       = pick_onehot;
          win_d       = pick_idx;
          cmd_d       = sel_cmd;
          addr_d      = sel_addr;
          bus_valid_d = 1'b1;
          state_d     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        cnt_d   = '0;
        state_d = ST_SNOOP;
      end
      ST_SNOOP: begin
        if (snoop_valid || snoop_expired) begin
          snoop_d = snoop_valid ? snoop_normalize(snoop_in) : SNOOP_NOHIT;
          if (is_invalidate) begin
            to_release = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (data_done) begin
          to_release = 1'b1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Entering RELEASE drops the grant and raises done for exactly that cycle.
    if (to_release) begin
      state_d = ST_RELEASE;
      gnt_d   = '0;
      done_d  = 1'b1;
      ptr_d   = ptr_after;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      ptr_q       <= '0;
      win_q       <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      snoop_q     <= SNOOP_NOHIT;
      cnt_q       <= '0;
      bus_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      snoop_q     <= snoop_d;
      cnt_q       <= cnt_d;
      bus_valid_q <= bus_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt          = gnt_q;
  assign bus_valid    = bus_valid_q;
  assign bus_cmd      = cmd_q;
  assign bus_addr     = addr_q;
  assign snoop_result = snoop_q;
  assign done         = done_q;
  assign busy         = busy_q;

endmodule

// File: doc/shared_bus_arbiter.md
# shared_bus_arbiter

Arbitrates ownership of the shared snooping bus among `REQUESTERS` bus masters (L2 cache instances, write-back path). Sequences each bus transaction through its phases: grant, address/command broadcast, snoop-result collection, data transfer, release. Sits between the L2 cache controllers and the shared operation/snoop buses. It is the single driver of the shared command/address lines and the single source of bus grants.

## Interface
Parameters:
- `REQUESTERS`, 4, number of bus masters (≥2).
- `COMMAND_SIZE`, 8, width of a bus command.
- `ADDRESS_SIZE`, 32, width of a bus address.
- `SNOOP_WAIT`, 3, max cycles spent in SNOOP before defaulting to NOHIT (≥1).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  REQUESTERS  per-master request; held high until that master sees `done`.
- `cmd_in`  in  REQUESTERS*COMMAND_SIZE  per-master command; slice i belongs to master i.
- `addr_in`  in  REQUESTERS*ADDRESS_SIZE  per-master address, same slicing.
- `snoop_valid`  in  1  snoop result present on `snoop_in` this cycle.
- `snoop_in`  in  2  snoop result: 00 HIT, 01 HITM, 10 NOHIT, 11 reserved (treated as NOHIT).
- `data_done`  in  1  data owner signals the last data beat.
- `gnt`  out  REQUESTERS  one-hot grant, or all-zero.
- `bus_valid`  out  1  command/address broadcast strobe.
- `bus_cmd`  out  COMMAND_SIZE  broadcast command.
- `bus_addr`  out  ADDRESS_SIZE  broadcast address.
- `snoop_result`  out  2  captured snoop result for the current transaction.
- `done`  out  1  one-cycle transaction-complete pulse.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ADDR, SNOOP, DATA, RELEASE.
- IDLE: if any `req` is high, pick the winner round-robin. Search starts at priority pointer `ptr` and ascends with wrap. Register the winner's `gnt` bit, command and address, then go to ADDR. With no request, stay in IDLE.
- ADDR (1 cycle):
  - `bus_valid`=1; `bus_cmd`/`bus_addr` carry the latched values.
  - Snoop counter cleared; go to SNOOP.
- SNOOP:
  - On the first cycle with `snoop_valid`=1, capture `snoop_in` (11 captured as 10) into `snoop_result`.
  - Otherwise, after `SNOOP_WAIT` cycles with no `snoop_valid`, capture 10 (NOHIT).
  - Then go to DATA, or go straight to RELEASE when the command is CMD_INVALIDATE.
- DATA: wait for `data_done`=1, then go to RELEASE. There is no timeout.
- RELEASE (1 cycle):
  - `done`=1, `gnt` cleared.
  - `ptr` set to winner+1 (mod REQUESTERS).
  - Go to IDLE.
- `gnt` is held constant from ADDR through RELEASE-1. A master dropping `req` mid-transaction does not abort the transaction.
- `bus_cmd`/`bus_addr`/`snoop_result` keep their values until the next grant.
- Unknown command codes are treated as data-carrying commands.

## Timing
- Reset (async assert; deassert takes effect at the next edge):
  - state IDLE, `ptr`=0.
  - `gnt`, `bus_valid`, `done`, `busy` = 0.
  - `bus_cmd`, `bus_addr` = 0; `snoop_result`=2'b10.
- Reset mid-transaction abandons the transaction; no `done` pulse is issued.
- Request latency: `req` high at edge T in IDLE gives `gnt` high after T. `bus_valid` is high in cycle T+1. SNOOP is entered at T+2.
- Minimum transaction (snoop_valid in first SNOOP cycle, `data_done` in first DATA cycle): `done` in cycle T+4, back in IDLE at T+5. The next grant is visible at T+6.
- A snoop timeout adds `SNOOP_WAIT`-1 cycles relative to an immediate snoop.
- `snoop_valid` and `data_done` are ignored outside SNOOP and DATA respectively.
- All outputs are registered; no combinational path from input to output.

## Structure
- Package `cache_bus_pkg` holds:
  - state enum.
  - command codes: CMD_NOP=0, CMD_READ=1, CMD_WRITE=2, CMD_INVALIDATE=3, CMD_RWIM=4.
  - snoop codes: SNOOP_HIT=2'b00, SNOOP_HITM=2'b01, SNOOP_NOHIT=2'b10.
- One sub-module `rr_picker`: combinational round-robin priority encoder. Inputs `req` and `ptr`; outputs one-hot winner and `any`.

## Test plan
- Single requester: master 2 requests READ at 0x0000_1040, snoop_valid with 01 in the first SNOOP cycle, `data_done` two cycles later. Required: `gnt`=0100; one `bus_valid` cycle carrying cmd 1 / addr 0x0000_1040; `snoop_result`=01; one `done` pulse; `ptr`=3.
- All four requesting continuously from reset: grant order 0,1,2,3,0; `gnt` never multi-hot; one idle cycle between RELEASE and the next ADDR.
- Snoop timeout: no `snoop_valid` → `snoop_result`=10 after exactly 3 SNOOP cycles. Also: `snoop_in`=11 with `snoop_valid` is captured as 10.
- INVALIDATE (cmd 3): DATA is skipped; `done` is asserted 3 cycles after `gnt` rises; a `data_done` pulse during SNOOP has no effect.
- Master drops `req` during DATA: the transaction still completes with `done`, and the grant passes to the next requester.
- `reset_n` asserted during DATA: all outputs return to reset values immediately. After release, a pending request from master 3 is granted first; pending masters 0 and 3 are granted 0 first (`ptr`=0).
